spi_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares one 3-wire SPI controller (the half-duplex byte controller used by the TM1638 and HT16D35A drivers) between several command sources. Each requester presents a complete transaction (out bytes, out count, in count, chip selects). The arbiter grants one requester at a time, runs the activate/busy handshake with the controller, returns the read bytes to the owner and pulses done. It sits between the per-chip drivers and the single `spi_controller_ht16d35a` instance that drives the shared pins.

---
 rtl/spi_cmd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// spi_cmd_arbiter: round-robin owner selection for one shared
// 3-wire SPI byte controller, with activate/busy handshake.
module spi_cmd_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int OUT_BYTES     = 5,
  parameter int IN_BYTES      = 4,
  parameter int NUM_SELECTS   = 1,
  parameter int START_TIMEOUT = 64,
  localparam int OSZ = $clog2(OUT_BYTES + 1),
  localparam int ISZ = $clog2(IN_BYTES + 1)
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ-1:0][OUT_BYTES-1:0][7:0]   req_out_data,
  input  logic [NUM_REQ-1:0][OSZ-1:0]              req_out_count,
  input  logic [NUM_REQ-1:0][ISZ-1:0]              req_in_count,
  input  logic [NUM_REQ-1:0][NUM_SELECTS-1:0]      req_in_cs,
  output logic [NUM_REQ-1:0]                       req_grant,
  output logic [NUM_REQ-1:0]                       req_done,
  output logic [NUM_REQ-1:0]                       req_err,
  output logic [NUM_REQ-1:0][IN_BYTES-1:0][7:0]    req_in_data,
  output logic                                     spi_activate,
  output logic [OUT_BYTES-1:0][7:0]                spi_out_data,
  output logic [OSZ-1:0]                           spi_out_count,
  output logic [ISZ-1:0]                           spi_in_count,
  output logic [NUM_SELECTS-1:0]                   spi_in_cs,
  input  logic                                     spi_busy,
  input  logic [IN_BYTES-1:0][7:0]                 spi_in_data,
  output logic                                     arb_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  state_t                      state;
  logic [IW-1:0]               rr_ptr;
  logic [IW-1:0]               gidx;
  logic [TW-1:0]               tcnt;
  logic                        err;
  logic                        upd;
  logic [IN_BYTES-1:0][7:0]    rd_buf;

  logic [IW-1:0]               pick;
  logic                        found;
  logic [IW-1:0]               idx;
  int                          sum;

  // first pending requester at or after rr_ptr, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ)
        sum = sum - NUM_REQ;
      idx = IW'(sum);
      if (req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign arb_busy = (state != S_IDLE);

  // grant / handshake / completion sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      gidx          <= '0;
      tcnt          <= '0;
      err           <= 1'b0;
      upd           <= 1'b0;
      rd_buf        <= '0;
      req_grant     <= '0;
      req_done      <= '0;
      req_err       <= '0;
      req_in_data   <= '0;
      spi_activate  <= 1'b0;
      spi_out_data  <= '0;
      spi_out_count <= '0;
      spi_in_count  <= '0;
      spi_in_cs     <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            gidx          <= pick;
            req_grant     <= ONE << pick;
            spi_out_data  <= req_out_data[pick];
            spi_out_count <= req_out_count[pick];
            spi_in_count  <= req_in_count[pick];
            spi_in_cs     <= req_in_cs[pick];
            upd           <= 1'b0;
            err           <= 1'b0;
            if (req_out_count[pick] == '0 &&
                req_in_count[pick] == '0) begin
              state <= S_COMPLETE;
            end else begin
              spi_activate <= 1'b1;
              tcnt         <= '0;
              state        <= S_WAIT_BUSY;
            end
          end
        end
        S_WAIT_BUSY: begin
          if (spi_busy) begin
            spi_activate <= 1'b0;
            state        <= S_WAIT_DONE;
          end else if (tcnt == T_LAST) begin
            spi_activate <= 1'b0;
            err          <= 1'b1;
            state        <= S_COMPLETE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            for (int b = 0; b < IN_BYTES; b++) begin
              if (b < int'(spi_in_count))
                rd_buf[b] <= spi_in_data[b];
              else
                rd_buf[b] <= req_in_data[gidx][b];
            end
            upd   <= 1'b1;
            state <= S_COMPLETE;
          end
        end
        S_COMPLETE: begin
          req_done[gidx] <= 1'b1;
          req_err[gidx]  <= err;
          req_grant      <= '0;
          if (upd)
            req_in_data[gidx] <= rd_buf;
          rr_ptr <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
          err    <= 1'b0;
          upd    <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb_spi_cmd_arbiter: directed vectors plus handshake,
// reset and contention sequences against a busy model.
module tb_spi_cmd_arbiter;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [1:0]             req;
  logic [1:0][4:0][7:0]   req_out_data;
  logic [1:0][2:0]        req_out_count;
  logic [1:0][2:0]        req_in_count;
  logic [1:0][0:0]        req_in_cs;
  logic [1:0]             req_grant;
  logic [1:0]             req_done;
  logic [1:0]             req_err;
  logic [1:0][3:0][7:0]   req_in_data;
  logic                   spi_activate;
  logic [4:0][7:0]        spi_out_data;
  logic [2:0]             spi_out_count;
  logic [2:0]             spi_in_count;
  logic [0:0]             spi_in_cs;
  logic                   spi_busy;
  logic [3:0][7:0]        spi_in_data;
  logic                   arb_busy;

  spi_cmd_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_out_data  (req_out_data),
    .req_out_count (req_out_count),
    .req_in_count  (req_in_count),
    .req_in_cs     (req_in_cs),
    .req_grant     (req_grant),
    .req_done      (req_done),
    .req_err       (req_err),
    .req_in_data   (req_in_data),
    .spi_activate  (spi_activate),
    .spi_out_data  (spi_out_data),
    .spi_out_count (spi_out_count),
    .spi_in_count  (spi_in_count),
    .spi_in_cs     (spi_in_cs),
    .spi_busy      (spi_busy),
    .spi_in_data   (spi_in_data),
    .arb_busy      (arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hot_bad = 0;

  int m_dly = 2;
  int m_len = 10;
  bit m_never = 1'b0;
  int mph;
  int mcnt;

  // controller model: busy rises m_dly cycles after activate
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_busy <= 1'b0;
      mph      <= 0;
      mcnt     <= 0;
    end else begin
      case (mph)
        0: if (spi_activate && !m_never) begin
          if (m_dly <= 1) begin
            spi_busy <= 1'b1;
            mph      <= 2;
          end else begin
            mph <= 1;
          end
          mcnt <= 1;
        end
        1: if (mcnt >= m_dly - 1) begin
          spi_busy <= 1'b1;
          mcnt     <= 1;
          mph      <= 2;
        end else begin
          mcnt <= mcnt + 1;
        end
        2: if (mcnt >= m_len) begin
          spi_busy <= 1'b0;
          mph      <= 3;
        end else begin
          mcnt <= mcnt + 1;
        end
        3: if (!spi_activate) mph <= 0;
        default: mph <= 0;
      endcase
    end
  end

  // grant must never be two-hot
  always @(negedge clk) begin
    if (reset_n === 1'b1 && !$onehot0(req_grant))
      hot_bad = hot_bad + 1;
  end

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int          g;
    logic [39:0] odata;
    logic [2:0]  ocnt;
    logic [2:0]  icnt;
    logic        cs;
    int          dly;
    int          len;
    bit          never;
    logic [31:0] mdata;
    int          exp_act;
    int          exp_done;
    logic        exp_err;
    logic [31:0] exp_in0;
    logic [31:0] exp_in1;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int n, input vec_t v);
    int act;
    int dk;
    logic e;
    logic [31:0] i0;
    logic [31:0] i1;
    act = 0;
    dk  = 0;
    e   = 1'b0;
    i0  = '0;
    i1  = '0;
    @(negedge clk);
    req_out_data[v.g]  = v.odata;
    req_out_count[v.g] = v.ocnt;
    req_in_count[v.g]  = v.icnt;
    req_in_cs[v.g]     = v.cs;
    m_dly       = v.dly;
    m_len       = v.len;
    m_never     = v.never;
    spi_in_data = v.mdata;
    req[v.g]    = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d grant", n), req_grant, 2'b01 << v.g);
        chk($sformatf("v%0d out_data", n), spi_out_data, v.odata);
        chk($sformatf("v%0d out_count", n), spi_out_count, v.ocnt);
        chk($sformatf("v%0d in_count", n), spi_in_count, v.icnt);
        chk($sformatf("v%0d cs", n), spi_in_cs, v.cs);
      end
      if (spi_activate) act++;
      if (req_done[v.g]) begin
        dk = k;
        e  = req_err[v.g];
        i0 = req_in_data[0];
        i1 = req_in_data[1];
        break;
      end
    end
    req[v.g] = 1'b0;
    chk($sformatf("v%0d done seen", n), dk != 0, 1'b1);
    if (v.exp_done != 0)
      chk($sformatf("v%0d done cycle", n), dk, v.exp_done);
    chk($sformatf("v%0d activate cycles", n), act, v.exp_act);
    chk($sformatf("v%0d err", n), e, v.exp_err);
    chk($sformatf("v%0d in_data0", n), i0, v.exp_in0);
    chk($sformatf("v%0d in_data1", n), i1, v.exp_in1);
  endtask

  initial begin
    int ord[6];
    int nd;
    bit hit;

    vecs[0] = '{0, 40'h40, 3'd1, 3'd0, 1'b1, 2, 10, 1'b0,
                32'h0, 3, 15, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1, 40'h9A, 3'd1, 3'd4, 1'b1, 2, 10, 1'b0,
                32'h44332211, 3, 15, 1'b0, 32'h0, 32'h44332211};
    vecs[2] = '{0, 40'h1122334455, 3'd5, 3'd2, 1'b0, 2, 10, 1'b0,
                32'hDDCCBBAA, 3, 15, 1'b0, 32'h0000BBAA, 32'h44332211};
    vecs[3] = '{1, 40'h0, 3'd0, 3'd0, 1'b1, 2, 10, 1'b0,
                32'hFFFFFFFF, 0, 2, 1'b0, 32'h0000BBAA, 32'h44332211};
    vecs[4] = '{0, 40'h77, 3'd1, 3'd2, 1'b1, 2, 10, 1'b1,
                32'h12345678, 64, 0, 1'b1, 32'h0000BBAA, 32'h44332211};
    vecs[5] = '{1, 40'h0, 3'd0, 3'd1, 1'b1, 2, 10, 1'b0,
                32'h00000055, 3, 15, 1'b0, 32'h0000BBAA, 32'h44332255};
    vecs[6] = '{0, 40'hA5A5, 3'd2, 3'd3, 1'b1, 4, 3, 1'b0,
                32'h04030201, 5, 10, 1'b0, 32'h00030201, 32'h44332255};

    reset_n       = 1'b0;
    req           = '0;
    req_out_data  = '0;
    req_out_count = '0;
    req_in_count  = '0;
    req_in_cs     = '0;
    spi_in_data   = '0;

    repeat (3) @(negedge clk);
    chk("reset grant", req_grant, 2'b00);
    chk("reset activate", spi_activate, 1'b0);
    chk("reset in_data", req_in_data, 64'h0);
    chk("reset arb_busy", arb_busy, 1'b0);
    chk("reset done", req_done, 2'b00);
    chk("reset out_data", spi_out_data, 40'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_vec(i, vecs[i]);

    // reset while the controller is busy (S_WAIT_DONE)
    @(negedge clk);
    req_out_data[0]  = 40'h3C;
    req_out_count[0] = 3'd1;
    req_in_count[0]  = 3'd4;
    m_dly       = 2;
    m_len       = 10;
    m_never     = 1'b0;
    spi_in_data = 32'hCAFEF00D;
    req[0]      = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (spi_busy && !spi_activate) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst reached wait_done", hit, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst grant", req_grant, 2'b00);
    chk("rst activate", spi_activate, 1'b0);
    chk("rst arb_busy", arb_busy, 1'b0);
    chk("rst in_data", req_in_data, 64'h0);
    chk("rst out_count", spi_out_count, 3'd0);
    req = '0;
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (req_done != 2'b00) nd++;
    end
    reset_n = 1'b1;
    chk("rst no done", nd, 0);

    // both requesters held high: strict alternation from 0
    @(negedge clk);
    req_out_data[0]  = 40'h10;
    req_out_data[1]  = 40'h20;
    req_out_count    = {3'd1, 3'd1};
    req_in_count     = {3'd0, 3'd0};
    req = 2'b11;
    nd  = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_done != 2'b00) begin
        ord[nd] = req_done[0] ? 0 : 1;
        nd++;
        if (nd == 6) break;
      end
    end
    req = 2'b00;
    chk("contend count", nd, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("contend order %0d", i), ord[i], i % 2);

    repeat (3) @(negedge clk);
    chk("final idle", arb_busy, 1'b0);
    chk("grant one-hot", hot_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
